onehot_to_bin: RTL
==================

Name: onehot_to_bin

Overview:
- Registered one-hot to binary decoder; the inverse of the team's binary-to-one-hot encoder (16-bit one-hot to 4-bit binary).
- Accepts one-hot words on a valid/ready stream and returns the binary index on a second valid/ready stream.
- Buffers results in a 2-entry output queue so upstream ready is a registered signal.
- Flags illegal codes (zero or multiple bits set) and counts them in a saturating counter for debug.

Parameters:
ONE_HOT_W, 16, width of the one-hot input word
BIN_W, 4, width of the binary output; must equal clog2(ONE_HOT_W)
ERR_CNT_W, 8, width of the saturating illegal-code counter

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
oh_valid_i  input  1  input word valid
oh_ready_o  output  1  block can accept a word this cycle (registered)
one_hot_i  input  ONE_HOT_W  one-hot input word
bin_valid_o  output  1  output entry valid
bin_ready_i  input  1  downstream accepts the output entry
bin_o  output  BIN_W  decoded binary index of the head entry
err_o  output  1  head entry came from an illegal code
err_cnt_o  output  ERR_CNT_W  number of illegal words accepted, saturating
clr_cnt_i  input  1  synchronous clear of err_cnt_o

Behaviour:
- Reset (rst=1 at a clock edge):
  - Queue empties.
  - bin_valid_o=0, bin_o=0, err_o=0, err_cnt_o=0, oh_ready_o=0.
  - oh_ready_o rises on the first edge with rst=0.
  - A reset mid-transfer discards all queued entries; no partial output.
- Transfer rules:
  - Input transfer when oh_valid_i && oh_ready_o at a rising edge.
  - Output transfer when bin_valid_o && bin_ready_i at a rising edge.
- Decode, evaluated on the word at input-transfer time:
  - Exactly one bit k set: bin=k, err=0.
  - Zero bits set: bin=0, err=1.
  - Two or more bits set: bin = index of the lowest set bit, err=1.
- Queue: 2-entry FIFO of {bin, err}. Count is 0, 1 or 2.
  - oh_ready_o is registered, equal to (next count < 2), so it is 1 whenever the queue will hold at most one entry.
  - bin_valid_o = (count != 0); bin_o and err_o always show the head entry.
  - When bin_valid_o=0, bin_o and err_o hold their last values.
- Latency: a word accepted into an empty queue appears on bin_o/bin_valid_o on the next cycle (1-cycle latency).
- Throughput: one word per cycle sustained while bin_ready_i=1.
- Input transfer and output transfer in the same cycle: count is unchanged and order is preserved. At count=1 the new entry becomes the head on the next cycle.
- Full (count=2): oh_ready_o=0. oh_valid_i is ignored and the word must be held upstream.
- Stable output: bin_valid_o, bin_o and err_o do not change while bin_valid_o=1 and bin_ready_i=0.
- Error counter:
  - Increments by 1 on each input transfer with err=1.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_cnt_i=1 forces 0 and takes priority over a same-cycle increment; that increment is lost.
- Width rule: if BIN_W < clog2(ONE_HOT_W), elaboration fails with an error.

Test Plan:
- Walk legal codes: after reset, drive one_hot_i = 1<<i for i=0..15, bin_ready_i=1. Required: bin_o=i one cycle after each accept, err_o=0, err_cnt_o stays 0, one word per cycle.
- Illegal codes: drive 16'h0000, 16'h0018, 16'hFFFF. Required: bin_o=0/3/0, err_o=1 each time, err_cnt_o=3.
- Backpressure: hold bin_ready_i=0 and offer 16'h0004, 16'h0100, 16'h8000. Required:
  - oh_ready_o=0 after two accepts; the third word stays held upstream.
  - Head shows bin_o=2, stable.
  - After releasing bin_ready_i, outputs in order 2, 8, 15.
- Simultaneous push/pop at count=1: no bubble, order preserved, oh_ready_o stays 1.
- Saturation and clear with ERR_CNT_W=2:
  - Send 5 zero words; required err_cnt_o=3.
  - Assert clr_cnt_i in the same cycle as an illegal accept; required err_cnt_o=0 the next cycle.
- Reset mid-operation: with 2 entries queued, assert rst for one cycle. Required:
  - bin_valid_o=0, err_cnt_o=0, oh_ready_o=0.
  - oh_ready_o=1 on the next cycle; no stale entry emitted.

Source files
------------

// File: rtl/onehot_to_bin.sv
// Registered one-hot to binary decoder with a 2-entry result queue on a valid/ready stream.
// Illegal codes (none or several bits set) are flagged and counted in a saturating counter.
module onehot_to_bin #(
  parameter int unsigned ONE_HOT_W = 16,
  parameter int unsigned BIN_W     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oh_valid_i,
  output logic                 oh_ready_o,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 bin_valid_o,
  input  logic                 bin_ready_i,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 clr_cnt_i
);

  if (BIN_W < $clog2(ONE_HOT_W)) begin : gen_width_check
    $error("onehot_to_bin: BIN_W is too narrow to index ONE_HOT_W bits");
  end

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } entry_t;

  // Decode: index of the lowest set bit, plus an illegal-code flag.
  logic [BIN_W-1:0] dec_bin;
  logic             dec_zero;
  logic             dec_multi;
  entry_t           in_entry;

  always_comb begin
    dec_bin = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
      if (one_hot_i[i]) begin
        dec_bin = BIN_W'(i);
      end
    end
  end

  assign dec_zero  = ~|one_hot_i;
  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign dec_multi = |(one_hot_i & (one_hot_i - ONE_HOT_W'(1)));

  always_comb begin
    in_entry     = '0;
    in_entry.bin = dec_bin;
    in_entry.err = dec_zero | dec_multi;
  end

  // Queue state: head_q is always the visible entry and keeps its value once drained.
  entry_t               head_q, head_d;
  entry_t               tail_q, tail_d;
  logic [1:0]           count_q, count_d;
  logic                 ready_q, ready_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 push;
  logic                 pop;

  assign push = oh_valid_i & ready_q;
  assign pop  = (count_q != 2'd0) & bin_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = in_entry;
        end else begin
          tail_d = in_entry;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Push needs count < 2 and pop needs count > 0, so count is 1: replace the head.
        head_d = in_entry;
      end
      default: begin
      end
    endcase
  end

  assign ready_d = (count_d != 2'd2);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt_i) begin
      err_cnt_d = '0;
    end else if (push && in_entry.err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= 2'd0;
      ready_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign oh_ready_o  = ready_q;
  assign bin_valid_o = (count_q != 2'd0);
  assign bin_o       = head_q.bin;
  assign err_o       = head_q.err;
  assign err_cnt_o   = err_cnt_q;

endmodule
